// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with packet-locked routing.
// Each output channel owns a single register slot, giving one cycle of latency.
module demux_1_4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_last,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [3:0]       out_last,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [1:0]       locked_reg;
  logic [1:0]       locked_next;
  logic [1:0]       ch;
  logic             accept;
  logic [3:0]       load;
  logic [WIDTH-1:0] data_reg [4];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      locked_reg <= 2'd0;
    end else begin
      state_reg  <= state_next;
      locked_reg <= locked_next;
    end
  end

  // Next-state logic: the channel is captured only on the first beat of a multi-beat packet
  always_comb begin
    state_next  = state_reg;
    locked_next = locked_reg;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (!in_last) begin
            state_next  = PKT;
            locked_next = in_sel;
          end
        end
        PKT: begin
          if (in_last) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic: routing, handshake and per-channel load strobes
  always_comb begin
    ch       = (state_reg == PKT) ? locked_reg : in_sel;
    in_ready = !out_valid[ch] || out_ready[ch];
    accept   = in_valid && in_ready;
    busy     = (state_reg == PKT);
    load     = accept ? (4'b0001 << ch) : 4'b0000;
  end

  // Per-channel slots; a load wins over a drain so a full channel streams at one beat per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 4'b0000;
      out_last  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          data_reg[i]  <= in_data;
          out_last[i]  <= in_last;
          out_valid[i] <= 1'b1;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign out_data0 = data_reg[0];
  assign out_data1 = data_reg[1];
  assign out_data2 = data_reg[2];
  assign out_data3 = data_reg[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: vector table, directed corner cases,
// and a random stress run checked by a per-channel scoreboard and a cycle model.
module tb_demux_1_4_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic       in_last;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_last;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic       busy;

  logic [3:0] od [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  demux_1_4_stream #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .out_data0(out_data0),
    .out_data1(out_data1),
    .out_data2(out_data2),
    .out_data3(out_data3),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  // Reference model state
  logic       m_pkt;
  logic [1:0] m_lock;
  logic [3:0] m_valid;
  logic [3:0] m_last;
  logic [3:0] m_data [4];
  logic       pre_in_ready;

  // Scoreboard: {last, data} per channel in acceptance order
  logic [4:0] sbq [4][$];

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic       last;
    logic [3:0] data;
    logic [3:0] rdy;
    logic       exp_rdy;
    logic [3:0] exp_valid;
    logic       exp_busy;
    logic [1:0] exp_ch;
    logic [3:0] exp_d;
    logic       exp_last;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pkt   = 1'b0;
    m_lock  = 2'd0;
    m_valid = 4'b0;
    m_last  = 4'b0;
    for (int i = 0; i < 4; i++) begin
      m_data[i] = 4'h0;
      sbq[i].delete();
    end
  endtask

  // One clock cycle: drive at negedge, check handshake before the edge, check outputs after it
  task automatic drive(input logic v, input logic [1:0] sel, input logic last,
                       input logic [3:0] data, input logic [3:0] rdy);
    logic [1:0] ch;
    logic       mr, acc;
    logic [3:0] stall, sl;
    logic [3:0] sd [4];
    logic [4:0] exp;
    in_valid  = v;
    in_sel    = sel;
    in_last   = last;
    in_data   = data;
    out_ready = rdy;
    #1;
    ch  = m_pkt ? m_lock : sel;
    mr  = !m_valid[ch] || rdy[ch];
    acc = v && mr;
    pre_in_ready = in_ready;
    check("in_ready", in_ready, mr);
    for (int i = 0; i < 4; i++) begin
      stall[i] = out_valid[i] && !rdy[i];
      sd[i]    = od[i];
      sl[i]    = out_last[i];
      if (out_valid[i] && rdy[i]) begin
        if (sbq[i].size() == 0) begin
          assertions++;
          failures++;
          $display("FAIL sb_spurious ch%0d: got beat %0h expected none", i, {out_last[i], od[i]});
        end else begin
          exp = sbq[i].pop_front();
          check($sformatf("sb_ch%0d", i), {out_last[i], od[i]}, exp);
        end
      end
    end
    if (acc) sbq[ch].push_back({last, data});
    for (int i = 0; i < 4; i++) begin
      if (acc && ch == 2'(i)) begin
        m_valid[i] = 1'b1;
        m_data[i]  = data;
        m_last[i]  = last;
      end else if (rdy[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    if (acc) begin
      if (!m_pkt && !last) begin
        m_pkt  = 1'b1;
        m_lock = sel;
      end else if (m_pkt && last) begin
        m_pkt = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("busy", busy, m_pkt);
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i]) check($sformatf("model_ch%0d", i), {out_last[i], od[i]}, {m_last[i], m_data[i]});
      if (stall[i]) check($sformatf("stable_ch%0d", i), {out_valid[i], out_last[i], od[i]}, {1'b1, sl[i], sd[i]});
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; in_sel = 2'd0; in_last = 1'b0; in_data = 4'h0; out_ready = 4'h0;
    model_reset();

    // Vector table: single beats, 3-beat packet, full throughput
    tbl[0] = '{1'b1, 2'd0, 1'b1, 4'h1, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 4'h1, 1'b1};
    tbl[1] = '{1'b1, 2'd1, 1'b1, 4'h2, 4'hF, 1'b1, 4'b0010, 1'b0, 2'd1, 4'h2, 1'b1};
    tbl[2] = '{1'b1, 2'd2, 1'b1, 4'h3, 4'hF, 1'b1, 4'b0100, 1'b0, 2'd2, 4'h3, 1'b1};
    tbl[3] = '{1'b1, 2'd3, 1'b1, 4'h4, 4'hF, 1'b1, 4'b1000, 1'b0, 2'd3, 4'h4, 1'b1};
    tbl[4] = '{1'b1, 2'd2, 1'b0, 4'hA, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hA, 1'b0};
    tbl[5] = '{1'b1, 2'd0, 1'b0, 4'hB, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hB, 1'b0};
    tbl[6] = '{1'b1, 2'd0, 1'b1, 4'hC, 4'hF, 1'b1, 4'b0100, 1'b0, 2'd2, 4'hC, 1'b1};
    tbl[7] = '{1'b0, 2'd0, 1'b0, 4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      tbl[8 + i] = '{1'b1, 2'd0, 1'b1, 4'(i), 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 4'(i), 1'b1};
    end
    tbl[16] = '{1'b0, 2'd0, 1'b0, 4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b0};

    // Reset state
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 4'b0);
    check("rst_out_last", out_last, 4'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", {out_data3, out_data2, out_data1, out_data0}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 17; t++) begin
      drive(tbl[t].v, tbl[t].sel, tbl[t].last, tbl[t].data, tbl[t].rdy);
      check($sformatf("tbl%0d_in_ready", t), pre_in_ready, tbl[t].exp_rdy);
      check($sformatf("tbl%0d_valid", t), out_valid, tbl[t].exp_valid);
      check($sformatf("tbl%0d_busy", t), busy, tbl[t].exp_busy);
      if (tbl[t].exp_valid != 4'b0) begin
        check($sformatf("tbl%0d_data", t), od[tbl[t].exp_ch], tbl[t].exp_d);
        check($sformatf("tbl%0d_last", t), out_last[tbl[t].exp_ch], tbl[t].exp_last);
      end
    end

    // Backpressure on ch1 while ch3 keeps flowing
    drive(1'b1, 2'd1, 1'b1, 4'h5, 4'b1101);
    check("bp_first_valid", out_valid, 4'b0010);
    check("bp_first_data", out_data1, 4'h5);
    drive(1'b1, 2'd1, 1'b1, 4'h6, 4'b1101);
    check("bp_blocked_ready", pre_in_ready, 1'b0);
    check("bp_held_data", out_data1, 4'h5);
    drive(1'b1, 2'd3, 1'b1, 4'h7, 4'b1101);
    check("bp_side_ready", pre_in_ready, 1'b1);
    check("bp_side_valid", out_valid, 4'b1010);
    check("bp_side_data", out_data3, 4'h7);
    drive(1'b1, 2'd1, 1'b1, 4'h6, 4'b1111);
    check("bp_release_ready", pre_in_ready, 1'b1);
    check("bp_release_data", out_data1, 4'h6);
    check("bp_release_valid", out_valid, 4'b0010);
    drive(1'b0, 2'd0, 1'b0, 4'h0, 4'hF);

    // Reset in the middle of a 4-beat packet to ch3
    drive(1'b1, 2'd3, 1'b0, 4'hD, 4'b0111);
    drive(1'b1, 2'd0, 1'b0, 4'hE, 4'b0111);
    check("mid_busy_before", busy, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 4'b0);
    check("mid_rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 2'd1, 1'b1, 4'h9, 4'hF);
    check("mid_after_valid", out_valid, 4'b0010);
    check("mid_after_data", out_data1, 4'h9);
    drive(1'b0, 2'd0, 1'b0, 4'h0, 4'hF);

    // Random stress
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), r);
    end

    // Bounded drain, then every queue must be empty
    for (int c = 0; c < 8; c++) drive(1'b0, 2'd0, 1'b0, 4'h0, 4'hF);
    for (int i = 0; i < 4; i++) check($sformatf("drain_empty_ch%0d", i), sbq[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/demux_1_4_stream.md
Name: demux_1_4_stream

Overview:
- Registered 1-to-4 stream demultiplexer. It is the distribution counterpart of the 4:1 selection muxes: one valid/ready input stream fans out to four valid/ready output channels.
- Routing is packet-based. The channel is taken from in_sel on the first beat of a packet and held until the beat with in_last.
- Each output channel has a one-entry register slot, so input-to-output latency is 1 cycle.
- Used wherever a shared producer feeds four consumers, e.g. splitting a merged bus back into per-lane streams.

Parameters:
- WIDTH, 4, data width of the input and of each output channel.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH  input beat payload.
- in_sel  input  2  destination channel; sampled only on the first beat of a packet.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  4  per-channel valid; bit i belongs to channel i.
- out_ready  input  4  per-channel ready from the consumers.
- out_last  output  4  per-channel last flag for the beat held in the slot.
- out_data0, out_data1, out_data2, out_data3  output  WIDTH each  per-channel payload.
- busy  output  1  high while a multi-beat packet is in progress (state PKT).

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_last=0, all out_dataN=0.
  - State goes to IDLE, locked channel = 0, busy=0.
  - Any buffered beats are discarded.
  - Outputs hold these values while rst_n stays low.
- State machine:
  - IDLE: route channel ch = in_sel.
  - PKT: ch = locked_sel; in_sel is ignored.
- Handshake:
  - in_ready = !out_valid[ch] || out_ready[ch]. This is combinational from in_sel/out_ready; no combinational path from in_valid to in_ready.
  - A beat is accepted when in_valid && in_ready.
  - On accept: slot[ch].data <= in_data, out_last[ch] <= in_last, out_valid[ch] <= 1.
- Transitions on accept:
  - IDLE and !in_last: go to PKT, locked_sel <= in_sel.
  - IDLE and in_last: stay IDLE (single-beat packet).
  - PKT and in_last: go to IDLE.
  - PKT and !in_last: stay PKT.
  - With no accept there is no state change, including in_valid high while in_ready is low.
- Drain:
  - Channel i with out_valid[i] && out_ready[i] and no accept into i that cycle: out_valid[i] <= 0.
  - out_data/out_last hold their last value after drain.
- Simultaneous drain and accept on the same channel: the new beat replaces the old one and out_valid stays 1. This gives full throughput of 1 beat/cycle per channel.
- Channels drain independently. A stalled channel i does not block accepts to channel j ≠ i while the block is in IDLE. In PKT, any stall of the locked channel stalls the input.
- Stability: while out_valid[i] && !out_ready[i], out_dataN and out_last[i] stay constant.
- Latency: a beat accepted at edge k appears at out_* after edge k (visible in cycle k+1).
- Ordering: beats on a given channel leave in acceptance order. Packets are never interleaved on the input side.
- busy = (state == PKT).
- Reset mid-packet: state returns to IDLE. The next accepted beat's in_sel chooses a fresh channel, and the remaining tail is not awaited.

Test Plan:
- Reset, then single beats to channels 0..3 (in_sel=0,1,2,3, data 4'h1,4'h2,4'h3,4'h4, in_last=1, all out_ready=1):
  - each data appears on out_dataN one cycle later with out_valid one-hot and out_last=1;
  - busy stays 0.
- 3-beat packet (data A,B,C) with in_sel=2 on beat 1 and in_sel=0 on beats 2-3:
  - all three beats appear on channel 2;
  - busy=1 after beat 1, busy=0 after C;
  - channel 0 never asserts valid.
- Backpressure:
  - out_ready[1]=0, send 5 to ch1 then 6 to ch1: out_data1=5 held, in_ready=0 for the second beat.
  - Raise out_ready[1]: 6 is accepted that same cycle and appears next cycle.
  - Meanwhile a beat 7 to ch3 is accepted while ch1 is stalled in IDLE.
- Full throughput: ch0 with out_ready[0]=1, 8 consecutive beats 0..7 → in_ready constantly 1, out_data0 follows the input one cycle later with no bubbles.
- Reset mid-packet: assert rst_n=0 after beat 2 of a 4-beat packet to ch3 → out_valid=0 immediately (asynchronous), busy=0; the next beat with in_sel=1 routes to ch1.
- Random stress over 2000 cycles (random valid/ready/sel/last): scoreboard per channel confirms order, no loss, no duplication, and data stability under stall.
